serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle adder/subtractor. Adds two WIDTH-bit operands BITS_PER_CYCLE bits per clock, using a registered carry between chunks.
- Generalises the team's combinational half-adder cell in four ways: width, per-cycle chunk size, carry-in, and subtract mode.
- Start/busy/done handshake; the result is held until the next operation.
- Used in area-constrained datapaths where a full-width carry chain is not wanted.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in; sampled with start; ignored when sub=1.
- sub  input  1  0 gives a+b+cin; 1 gives a−b (computed as a+~b+1); sampled with start.
- busy  output  1  high from the edge that accepts start until done is asserted.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry-out of the MSB. In sub mode: 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asynchronous, active-low, any time, including mid-operation):
  - state=IDLE.
  - busy, done, sum, cout and overflow all 0.
  - Internal operand shift registers, carry and chunk counter all 0.
  - Any in-flight result is discarded.
- Definitions: N = WIDTH/BITS_PER_CYCLE; B' = sub ? ~b : b; c0 = sub ? 1 : cin.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1: latch a and B' into shift registers, carry←c0, counter←0, state←RUN, busy←1.
  - sum, cout and overflow keep their old values until DONE.
  - start=0: stay in IDLE.
- RUN:
  - Each edge: add the low BITS_PER_CYCLE bits of the A register, the B' register and carry using a chain of BITS_PER_CYCLE full-adder cells.
  - Write the chunk into the partial-sum register from the MSB end, shifting right by BITS_PER_CYCLE. Shift the A and B' registers right by BITS_PER_CYCLE. carry←chunk carry-out. counter++.
  - On the edge that processes chunk N−1: sum←final value, cout←final carry, overflow←(A_msb==B'_msb)&&(sum_msb!=A_msb) using the latched MSBs, busy←0, done←1, state←DONE.
- DONE: lasts exactly one cycle; done←0 and state←IDLE on the next edge.
- start in RUN or DONE is ignored; it is not queued.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- Latency: start accepted at edge E → done high during the cycle after edge E+N → next start can be accepted at edge E+N+2.
  - WIDTH=8, BITS_PER_CYCLE=1: done after edge E+8.
  - BITS_PER_CYCLE=WIDTH: done after edge E+1.
- Arithmetic:
  - Result is modulo 2^WIDTH; there is no saturation.
  - The internal counter is $clog2(N)+1 bits wide. It must never wrap within an operation.
- Changes to a, b, cin or sub during RUN have no effect.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Helper function for the counter width.
- Sub-module full_adder_cell (a, b, cin → s, cout), built from two half-adder cells plus an OR gate.
- Instantiate BITS_PER_CYCLE full_adder_cell instances with a generate loop to form the chunk adder.

Test Plan:
1. WIDTH=8, BPC=1: start with a=0x3C, b=0x5A, cin=0, sub=0 → done pulse exactly 8 edges after acceptance; sum=0x96, cout=0, overflow=1; busy high for those 8 cycles.
2. Subtract: a=0x10, b=0x20, sub=1, cin=1 (cin must be ignored) → sum=0xF0, cout=0 (borrow), overflow=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
3. Carry/wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
4. start pulsed again 3 cycles into RUN with different operands → ignored: first result unchanged, a single done pulse. start held high for 20 cycles → back-to-back operations, done every 10 cycles.
5. Deassert rst_n asynchronously (between edges) 4 cycles into RUN → busy, done, sum, cout and overflow go to 0 immediately; after release, no done until a new start; the next operation produces a correct result.
6. WIDTH=16, BPC=4: a=0x7FFF, b=0x0001 → done 4 edges after acceptance, sum=0x8000, cout=0, overflow=1. Sweep random operands against a reference model, 1000 vectors across both modes.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // One spare bit so the chunk counter cannot wrap within an operation.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: two half-adder stages whose carries are OR-ed.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: BITS_PER_CYCLE bits per clock with a registered
// carry between chunks; start/busy/done handshake, result held until next op.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_w(N);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, b_q, psum_q, psum_d;
  logic                    carry_q;
  logic [CW-1:0]           cnt_q;
  logic                    a_msb_q, b_msb_q;
  logic [BITS_PER_CYCLE:0] c;
  logic [BITS_PER_CYCLE-1:0] chunk_s;
  logic                    accept, last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
    full_adder_cell u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (c[i]),
      .s    (chunk_s[i]),
      .cout (c[i+1])
    );
  end

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == RUN) && (cnt_q == CW'(N - 1));

  // New chunk enters at the MSB end; after N chunks the LSB chunk has reached bit 0.
  assign psum_d = (psum_q >> BITS_PER_CYCLE) | (WIDTH'(chunk_s) << (WIDTH - BITS_PER_CYCLE));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      cnt_q   <= '0;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_q     <= a_q >> BITS_PER_CYCLE;
      b_q     <= b_q >> BITS_PER_CYCLE;
      psum_q  <= psum_d;
      carry_q <= c[BITS_PER_CYCLE];
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        sum      <= psum_d;
        cout     <= c[BITS_PER_CYCLE];
        overflow <= (a_msb_q == b_msb_q) && (psum_d[WIDTH-1] != a_msb_q);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three configurations (8/1, 16/4, 8/8), directed table,
// multi-cycle handshake corners, async reset, and a random sweep vs a model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  st = '0, icin = '0, isub = '0;
  logic [15:0] ia [3];
  logic [15:0] ib [3];
  wire  [2:0]  bz, dn, co, ov;
  wire  [7:0]  s0, s2;
  wire  [15:0] s1;

  int checks = 0;
  int failures = 0;
  int nchunks [3] = '{8, 4, 1};
  int widths  [3] = '{8, 16, 8};

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ia[0][7:0]), .b(ib[0][7:0]),
    .cin(icin[0]), .sub(isub[0]), .busy(bz[0]), .done(dn[0]), .sum(s0),
    .cout(co[0]), .overflow(ov[0]));

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ia[1]), .b(ib[1]),
    .cin(icin[1]), .sub(isub[1]), .busy(bz[1]), .done(dn[1]), .sum(s1),
    .cout(co[1]), .overflow(ov[1]));

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(ia[2][7:0]), .b(ib[2][7:0]),
    .cin(icin[2]), .sub(isub[2]), .busy(bz[2]), .done(dn[2]), .sum(s2),
    .cout(co[2]), .overflow(ov[2]));

  function automatic logic [15:0] sum_of(input int k);
    case (k)
      0:       return {8'h00, s0};
      1:       return s1;
      default: return {8'h00, s2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s, output logic [15:0] r,
                                 output logic rco, output logic rov);
    longint m, ua, ub, t, sa, sb, ts;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    t  = s ? (ua - ub) : (ua + ub + longint'(c));
    r  = 16'(t & m);
    rco = s ? (ua >= ub) : ((t >> w) != 0);
    sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    ts = s ? (sa - sb) : (sa + sb + longint'(c));
    rov = (ts > (m >> 1)) || (ts < -((m + 1) / 2));
  endfunction

  // One operation on DUT k; checks busy through RUN, done latency and pulse width.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, output logic [15:0] r_sum,
                        output logic r_co, output logic r_ov);
    int lat;
    @(negedge clk);
    ia[k] = a; ib[k] = b; icin[k] = c; isub[k] = s; st[k] = 1'b1;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    ia[k] = 16'($urandom); ib[k] = 16'($urandom);
    icin[k] = 1'($urandom); isub[k] = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dn[k]) begin lat = i - 1; break; end
      chk("busy_in_run", 64'(bz[k]), 64'd1);
    end
    chk("done_latency", 64'(lat), 64'(nchunks[k]));
    chk("busy_at_done", 64'(bz[k]), 64'd0);
    r_sum = sum_of(k); r_co = co[k]; r_ov = ov[k];
    @(negedge clk);
    chk("done_one_cycle", 64'(dn[k]), 64'd0);
  endtask

  typedef struct {
    int          k;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        co, ov;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [15:0] rs, es;
    logic rc, ro, ec, eo;
    int ndone, first_sum_ok;
    int didx[$];

    for (int k = 0; k < 3; k++) begin ia[k] = '0; ib[k] = '0; end

    tbl.push_back('{0, 16'h3C, 16'h5A, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1});
    tbl.push_back('{0, 16'h10, 16'h20, 1'b1, 1'b1, 16'hF0, 1'b0, 1'b0});
    tbl.push_back('{0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1});
    tbl.push_back('{0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0});
    tbl.push_back('{0, 16'hFF, 16'h00, 1'b1, 1'b0, 16'h00, 1'b1, 1'b0});
    tbl.push_back('{0, 16'h00, 16'h80, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1});
    tbl.push_back('{0, 16'h00, 16'h00, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0});
    tbl.push_back('{1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{1, 16'h1234, 16'h4321, 1'b1, 1'b1, 16'hCF13, 1'b0, 1'b0});
    tbl.push_back('{2, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1});
    tbl.push_back('{2, 16'h05, 16'h07, 1'b0, 1'b1, 16'hFE, 1'b0, 1'b0});

    // Reset state
    #3;
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_sum0", 64'(s0), 64'd0);
    chk("rst_sum1", 64'(s1), 64'd0);
    chk("rst_cout", 64'(co), 64'd0);
    chk("rst_ovf",  64'(ov), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro);
      chk($sformatf("tbl%0d_sum", i), 64'(rs), 64'(tbl[i].sum));
      chk($sformatf("tbl%0d_cout", i), 64'(rc), 64'(tbl[i].co));
      chk($sformatf("tbl%0d_ovf", i), 64'(ro), 64'(tbl[i].ov));
    end

    // start re-pulsed 3 cycles into RUN with other operands: ignored
    @(negedge clk);
    ia[0] = 16'h3C; ib[0] = 16'h5A; icin[0] = 0; isub[0] = 0; st[0] = 1;
    ndone = 0; first_sum_ok = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (dn[0]) begin ndone++; if (s0 == 8'h96) first_sum_ok++; end
      st[0] = (i == 3);
      if (i == 3) begin ia[0] = 16'h11; ib[0] = 16'h22; end
    end
    chk("ignored_start_done_count", 64'(ndone), 64'd1);
    chk("ignored_start_sum", 64'(first_sum_ok), 64'd1);

    // start held high: back-to-back, done every N+2 cycles
    @(negedge clk);
    ia[0] = 16'h21; ib[0] = 16'h13; icin[0] = 1; isub[0] = 0; st[0] = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        didx.push_back(i);
        chk("held_sum", 64'(s0), 64'h35);
      end
    end
    st[0] = 0;
    chk("held_done_count", 64'(didx.size()), 64'd4);
    for (int i = 1; i < didx.size(); i++)
      chk("held_done_spacing", 64'(didx[i] - didx[i-1]), 64'd10);
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (dn[0]) break; end
    @(negedge clk);

    // Async reset mid-RUN discards the in-flight operation
    run_op(0, 16'h80, 16'h01, 1'b0, 1'b1, rs, rc, ro);
    chk("pre_rst_sum", 64'(rs), 64'h7F);
    @(negedge clk);
    ia[0] = 16'h3C; ib[0] = 16'h5A; icin[0] = 0; isub[0] = 0; st[0] = 1;
    @(posedge clk); #1 st[0] = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bz[0]), 64'd0);
    chk("arst_done", 64'(dn[0]), 64'd0);
    chk("arst_sum",  64'(s0), 64'd0);
    chk("arst_cout", 64'(co[0]), 64'd0);
    chk("arst_ovf",  64'(ov[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (dn[0] || bz[0]) ndone++; end
    chk("post_rst_idle", 64'(ndone), 64'd0);
    run_op(0, 16'h3C, 16'h5A, 1'b0, 1'b0, rs, rc, ro);
    chk("post_rst_sum", 64'(rs), 64'h96);
    chk("post_rst_ovf", 64'(ro), 64'd1);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [15:0] ra, rb;
      logic rci, rsb;
      k   = i % 3;
      ra  = 16'($urandom); rb = 16'($urandom);
      if (widths[k] == 8) begin ra[15:8] = '0; rb[15:8] = '0; end
      rci = 1'($urandom); rsb = 1'($urandom);
      ref_op(widths[k], ra, rb, rci, rsb, es, ec, eo);
      run_op(k, ra, rb, rci, rsb, rs, rc, ro);
      chk($sformatf("rnd%0d_sum", i), 64'(rs), 64'(es));
      chk($sformatf("rnd%0d_cout", i), 64'(rc), 64'(ec));
      chk($sformatf("rnd%0d_ovf", i), 64'(ro), 64'(eo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
